// File: rtl/sb_tid_manager_pkg.sv
// Shared types and default sizing for the scoreboard transaction-ID manager.
package sb_tid_manager_pkg;

  localparam int NR_SB_ENTRIES = 8;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef enum logic [1:0] {
    SB_FREE   = 2'd0,
    SB_ISSUED = 2'd1,
    SB_DONE   = 2'd2
  } sb_state_t;

endpackage

// File: rtl/sb_slot_fsm.sv
// One scoreboard slot: FREE -> ISSUED -> DONE -> FREE, plus a sticky exception flag.
// Flush returns the slot to FREE but keeps ex; only reset or a new allocation clears it.
module sb_slot_fsm
  import sb_tid_manager_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       alloc,
  input  logic       wb_hit,
  input  logic       wb_ex,
  input  logic       retire,
  output logic [1:0] state,
  output logic       ex
);

  sb_state_t state_q, state_n;
  logic      ex_q, ex_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_FREE;
      ex_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      ex_q    <= ex_n;
    end
  end

  always_comb begin
    state_n = state_q;
    ex_n    = ex_q;
    if (flush) begin
      state_n = SB_FREE;
    end else begin
      unique case (state_q)
        SB_FREE: begin
          if (alloc) begin
            state_n = SB_ISSUED;
            ex_n    = 1'b0;
          end
        end
        SB_ISSUED: begin
          if (wb_hit) begin
            state_n = SB_DONE;
            ex_n    = ex_q | wb_ex;
          end
        end
        SB_DONE: begin
          if (retire) state_n = SB_FREE;
        end
        default: state_n = SB_FREE;
      endcase
    end
  end

  assign state = state_q;
  assign ex    = ex_q;

endmodule

// File: rtl/sb_tid_manager.sv
// Circular transaction-ID pool: in-order allocation, out-of-order completion, in-order commit.
// Full/valid come from registered state only; there is no commit->issue or wb->commit bypass.
module sb_tid_manager
  import sb_tid_manager_pkg::*;
#(
  parameter int NR_ENTRIES = NR_SB_ENTRIES,
  parameter int ID_W       = TRANS_ID_BITS,
  parameter int NR_WB      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  issue_req_i,
  output logic                  issue_gnt_o,
  output logic [ID_W-1:0]       issue_id_o,
  input  logic [NR_WB-1:0]      wb_valid_i,
  input  logic [NR_WB*ID_W-1:0] wb_id_i,
  input  logic [NR_WB-1:0]      wb_ex_i,
  output logic                  commit_valid_o,
  output logic [ID_W-1:0]       commit_id_o,
  output logic                  commit_ex_o,
  input  logic                  commit_ack_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ID_W:0]         count_o
);

  logic [ID_W-1:0]       issue_ptr, commit_ptr;
  logic [ID_W:0]         count;
  logic                  issue_fire, commit_fire;
  logic [NR_ENTRIES-1:0] alloc, retire, wb_hit, wb_ex;
  logic [NR_ENTRIES-1:0] slot_done, slot_ex;
  logic [1:0]            slot_state [NR_ENTRIES];

  assign full_o      = (count == (ID_W+1)'(NR_ENTRIES));
  assign empty_o     = (count == '0);
  assign count_o     = count;
  assign issue_gnt_o = !full_o && !flush_i;
  assign issue_id_o  = issue_ptr;
  assign issue_fire  = issue_req_i && issue_gnt_o;

  assign commit_valid_o = slot_done[commit_ptr];
  assign commit_id_o    = commit_ptr;
  assign commit_ex_o    = slot_ex[commit_ptr];
  assign commit_fire    = commit_valid_o && commit_ack_i && !flush_i;

  // Decode pointers and writeback ports into per-slot strobes; the slot itself
  // decides whether a writeback is legal for its current state.
  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      alloc[i]  = issue_fire  && (issue_ptr  == ID_W'(i));
      retire[i] = commit_fire && (commit_ptr == ID_W'(i));
      wb_hit[i] = 1'b0;
      wb_ex[i]  = 1'b0;
      for (int k = 0; k < NR_WB; k++) begin
        if (wb_valid_i[k] && (wb_id_i[k*ID_W +: ID_W] == ID_W'(i))) begin
          wb_hit[i] = 1'b1;
          wb_ex[i]  = wb_ex[i] | wb_ex_i[k];
        end
      end
    end
  end

  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_slot
    sb_slot_fsm u_slot (
      .clk    (clk_i),
      .rst    (rst_i),
      .flush  (flush_i),
      .alloc  (alloc[g]),
      .wb_hit (wb_hit[g]),
      .wb_ex  (wb_ex[g]),
      .retire (retire[g]),
      .state  (slot_state[g]),
      .ex     (slot_ex[g])
    );
    assign slot_done[g] = (slot_state[g] == SB_DONE);
  end

  // Pointers wrap naturally because NR_ENTRIES is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      issue_ptr  <= '0;
      commit_ptr <= '0;
      count      <= '0;
    end else begin
      if (issue_fire)  issue_ptr  <= issue_ptr + 1'b1;
      if (commit_fire) commit_ptr <= commit_ptr + 1'b1;
      count <= count + (ID_W+1)'(issue_fire) - (ID_W+1)'(commit_fire);
    end
  end

endmodule

// File: tb/tb_sb_tid_manager.sv
// Randomized and directed bench for sb_tid_manager against an in-order queue model.
module tb_sb_tid_manager;
  localparam int N = 8;
  localparam int W = 3;
  localparam int P = 4;

  logic           clk_i = 1'b0;
  logic           rst_i, flush_i, issue_req_i, commit_ack_i;
  logic           issue_gnt_o, commit_valid_o, commit_ex_o, full_o, empty_o;
  logic [W-1:0]   issue_id_o, commit_id_o;
  logic [P-1:0]   wb_valid_i, wb_ex_i;
  logic [P*W-1:0] wb_id_i;
  logic [W:0]     count_o;

  int checks = 0;
  int errors = 0;

  // Model: program-order queue of in-flight IDs plus per-ID completion/exception.
  int q[$];
  bit inq[N];
  bit done_m[N];
  bit ex_m[N];
  int next_id;

  sb_tid_manager dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_req_i(issue_req_i), .issue_gnt_o(issue_gnt_o), .issue_id_o(issue_id_o),
    .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i), .wb_ex_i(wb_ex_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_ex_o(commit_ex_o),
    .commit_ack_i(commit_ack_i), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [P*W-1:0] ids(input int a, input int b, input int c, input int d);
    bit [P*W-1:0] v;
    v[0*W +: W] = W'(a);
    v[1*W +: W] = W'(b);
    v[2*W +: W] = W'(c);
    v[3*W +: W] = W'(d);
    return v;
  endfunction

  task automatic model_clear(input bit clr_ex);
    q.delete();
    next_id = 0;
    for (int i = 0; i < N; i++) begin
      inq[i] = 0;
      done_m[i] = 0;
      if (clr_ex) ex_m[i] = 0;
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model.
  task automatic step(input bit req, input bit [P-1:0] wv, input bit [P*W-1:0] wid,
                      input bit [P-1:0] wx, input bit ack, input bit fl, input bit rs);
    bit pre_in[N];
    bit pre_done[N];
    bit cv;
    bit gnt;
    int id;
    issue_req_i  = req;
    wb_valid_i   = wv;
    wb_id_i      = wid;
    wb_ex_i      = wx;
    commit_ack_i = ack;
    flush_i      = fl;
    rst_i        = rs;
    #1;
    cv  = (q.size() > 0) && done_m[q[0]];
    gnt = !fl && (q.size() < N);
    chk("gnt", int'(issue_gnt_o), int'(gnt));
    chk("issue_id", int'(issue_id_o), next_id);
    chk("commit_valid", int'(commit_valid_o), int'(cv));
    chk("commit_id", int'(commit_id_o), (q.size() > 0) ? q[0] : next_id);
    if (cv) chk("commit_ex", int'(commit_ex_o), int'(ex_m[q[0]]));
    chk("full", int'(full_o), int'(q.size() == N));
    chk("empty", int'(empty_o), int'(q.size() == 0));
    chk("count", int'(count_o), q.size());

    if (rs) model_clear(1);
    else if (fl) model_clear(0);
    else begin
      pre_in = inq;
      pre_done = done_m;
      for (int k = 0; k < P; k++) begin
        if (wv[k]) begin
          id = int'(wid[k*W +: W]);
          if (pre_in[id] && !pre_done[id]) begin
            done_m[id] = 1;
            ex_m[id] = ex_m[id] | wx[k];
          end
        end
      end
      if (cv && ack) begin
        id = q.pop_front();
        inq[id] = 0;
        done_m[id] = 0;
      end
      if (req && gnt) begin
        q.push_back(next_id);
        inq[next_id] = 1;
        done_m[next_id] = 0;
        ex_m[next_id] = 0;
        next_id = (next_id + 1) % N;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    step(0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, '0, '0, '0, 0, 0, 1);
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) step(1, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic wb1(input int id, input bit ex);
    step(0, 4'b0001, ids(id, 0, 0, 0), {3'b000, ex}, 0, 0, 0);
  endtask

  task automatic ack1();
    step(0, '0, '0, '0, 1, 0, 0);
  endtask

  initial begin
    rst_i = 1; flush_i = 0; issue_req_i = 0; commit_ack_i = 0;
    wb_valid_i = '0; wb_id_i = '0; wb_ex_i = '0;
    model_clear(1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    #1;
    chk("rst_commit_ex", int'(commit_ex_o), 0);

    // 8 back-to-back issues then a 9th request that must be refused
    issue_n(9);
    chk("full_after8", int'(full_o), 1);
    chk("count_after8", int'(count_o), 8);
    idle();

    // in-order retire with out-of-order writeback
    do_reset();
    issue_n(3);
    wb1(2, 0);
    wb1(0, 0);
    chk("head0_valid", int'(commit_valid_o), 1);
    ack1();
    idle();
    chk("head1_wait", int'(commit_valid_o), 0);
    wb1(1, 0);
    ack1();
    ack1();
    idle();

    // same-ID dual writeback ORs exceptions; writeback to a FREE slot is ignored
    do_reset();
    issue_n(4);
    step(0, 4'b0011, ids(3, 3, 0, 0), 4'b0010, 0, 0, 0);
    wb1(5, 1);
    step(0, 4'b0111, ids(0, 1, 2, 0), 4'b0000, 0, 0, 0);
    repeat (3) ack1();
    chk("head3_ex", int'(commit_ex_o), 1);
    repeat (2) ack1();
    idle();

    // full pool: simultaneous issue+commit only commits, then wraps to ID 0
    do_reset();
    issue_n(8);
    wb1(0, 0);
    step(1, '0, '0, '0, 1, 0, 0);
    chk("full_commit_count", int'(count_o), 7);
    step(1, '0, '0, '0, 0, 0, 0);
    idle();

    // flush with concurrent issue and ack
    do_reset();
    issue_n(4);
    step(0, 4'b0011, ids(0, 1, 0, 0), 4'b0000, 0, 0, 0);
    step(1, '0, '0, '0, 1, 1, 0);
    chk("flush_empty", int'(empty_o), 1);
    idle();

    // reset mid-traffic, then a late writeback for an old ID
    do_reset();
    issue_n(5);
    step(1, 4'b0001, ids(1, 0, 0, 0), 4'b0001, 1, 0, 1);
    chk("rst_mid_cex", int'(commit_ex_o), 0);
    wb1(1, 1);
    idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0,
           P'($urandom & $urandom),
           ids($urandom_range(0, N-1), $urandom_range(0, N-1),
               $urandom_range(0, N-1), $urandom_range(0, N-1)),
           P'($urandom),
           ($urandom % 3) != 0,
           ($urandom % 64) == 0,
           ($urandom % 131) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
